// File: rtl/npu_pkg.sv
// Shared constants and helpers for the MAC output path: vector/beat geometry,
// last-beat keep mask and per-beat byte selection.
package npu_pkg;

    localparam int unsigned MAC_OUT_NUM = 18;
    localparam int unsigned DATA_WIDTH  = 8;
    localparam int unsigned OUT_BYTES   = 8;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned CNT_WIDTH   = 16;

    localparam int unsigned VEC_W      = MAC_OUT_NUM * DATA_WIDTH;
    localparam int unsigned OUT_W      = OUT_BYTES * DATA_WIDTH;
    localparam int unsigned BEATS      = (MAC_OUT_NUM + OUT_BYTES - 1) / OUT_BYTES;
    localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PAD_W      = BEATS * OUT_W;
    localparam int unsigned LAST_BYTES = MAC_OUT_NUM - (BEATS - 1) * OUT_BYTES;
    localparam logic [OUT_BYTES-1:0] LAST_KEEP = OUT_BYTES'((64'd1 << LAST_BYTES) - 64'd1);

    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

    // Clamp every negative int8 channel to zero.
    function automatic logic [VEC_W-1:0] relu_vec(input logic [VEC_W-1:0] v);
        logic [VEC_W-1:0] r;
        r = v;
        for (int c = 0; c < int'(MAC_OUT_NUM); c++) begin
            if (v[c*DATA_WIDTH + DATA_WIDTH - 1]) begin
                r[c*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
        return r;
    endfunction

    // Bytes of beat b; channels past the end of the vector read as zero.
    function automatic logic [OUT_W-1:0] beat_data(input logic [VEC_W-1:0] v,
                                                   input logic [BEAT_W-1:0] b);
        logic [PAD_W-1:0] p;
        logic [OUT_W-1:0] r;
        p = PAD_W'(v);
        r = '0;
        for (int i = 0; i < int'(BEATS); i++) begin
            if (b == BEAT_W'(i)) begin
                r = p[i*OUT_W +: OUT_W];
            end
        end
        return r;
    endfunction

    function automatic logic [OUT_BYTES-1:0] beat_keep(input logic [BEAT_W-1:0] b);
        return (b == BEAT_W'(BEATS - 1)) ? LAST_KEEP : '1;
    endfunction

endpackage

// File: rtl/npu_vec_fifo.sv
// Vector FIFO with registered occupancy/full and a look-ahead view of the
// head entry as it will be after this cycle's push/pop.
module npu_vec_fifo
    import npu_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [VEC_W-1:0] wdata_i,
    output logic [VEC_W-1:0] head_nxt_c_o,
    output logic             empty_nxt_c_o,
    output logic             full_o
);

    logic [VEC_W-1:0]      mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_q, wr_d;
    logic [FIFO_PTR_W-1:0] rd_q, rd_d;
    logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;
    logic                  full_q;

    // Pointer/occupancy update; a push landing on the next head bypasses memory.
    always_comb begin
        wr_d          = wr_q + FIFO_PTR_W'(push_i);
        rd_d          = rd_q + FIFO_PTR_W'(pop_i);
        cnt_d         = cnt_q + FIFO_CNT_W'(push_i) - FIFO_CNT_W'(pop_i);
        empty_nxt_c_o = (cnt_d == '0);
        head_nxt_c_o  = (push_i && (wr_q == rd_d)) ? wdata_i : mem_q[rd_d];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == FIFO_CNT_W'(FIFO_DEPTH));
            if (push_i) begin
                mem_q[wr_q] <= wdata_i;
            end
        end
    end

    assign full_o = full_q;

endmodule

// File: rtl/npu_out_serializer.sv
// Captures MAC result vectors (optional ReLU), buffers them, and streams each
// one out as BEATS valid/ready byte beats; drops and flags vectors when full.
module npu_out_serializer
    import npu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [VEC_W-1:0]     MAC_data_i,
    input  logic                 MAC_data_valid_i,
    input  logic                 relu_en_i,
    input  logic                 frame_start_i,
    output logic [OUT_W-1:0]     out_data_o,
    output logic [OUT_BYTES-1:0] out_keep_o,
    output logic                 out_last_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 fifo_full_o,
    output logic                 overflow_o,
    output logic [CNT_WIDTH-1:0] vec_count_o
);

    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic [OUT_W-1:0]     data_q, data_d;
    logic [OUT_BYTES-1:0] keep_q, keep_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic             hs, last_hs, push, drop;
    logic             fifo_full, empty_nxt;
    logic [VEC_W-1:0] wdata, head_nxt;

    assign wdata = relu_en_i ? relu_vec(MAC_data_i) : MAC_data_i;

    npu_vec_fifo u_fifo (
        .clk          (clk),
        .rstn         (rstn),
        .push_i       (push),
        .pop_i        (last_hs),
        .wdata_i      (wdata),
        .head_nxt_c_o (head_nxt),
        .empty_nxt_c_o(empty_nxt),
        .full_o       (fifo_full)
    );

    // Output beats are computed from next-cycle head/beat so every output is a flop.
    always_comb begin
        hs      = valid_q & out_ready_i;
        last_hs = hs & (beat_q == BEAT_W'(BEATS - 1));
        push    = MAC_data_valid_i & (~fifo_full | last_hs);
        drop    = MAC_data_valid_i & ~push;

        beat_d = beat_q;
        if (last_hs) begin
            beat_d = '0;
        end else if (hs) begin
            beat_d = beat_q + BEAT_W'(1);
        end

        valid_d = ~empty_nxt;
        data_d  = valid_d ? beat_data(head_nxt, beat_d) : '0;
        keep_d  = valid_d ? beat_keep(beat_d) : '0;
        last_d  = valid_d & (beat_d == BEAT_W'(BEATS - 1));

        // A same-cycle drop or completed vector wins over the frame clear.
        ovf_d = ovf_q;
        if (frame_start_i) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        cnt_d = cnt_q;
        if (frame_start_i) begin
            cnt_d = '0;
        end
        if (last_hs && (cnt_d != '1)) begin
            cnt_d = cnt_d + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            beat_q  <= beat_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_keep_o  = keep_q;
    assign out_last_o  = last_q;
    assign out_valid_o = valid_q;
    assign fifo_full_o = fifo_full;
    assign overflow_o  = ovf_q;
    assign vec_count_o = cnt_q;

endmodule

// File: tb/tb_npu_out_serializer.sv
// Scoreboard bench for npu_out_serializer: an occupancy-level reference model
// queues expected beats on accepted writes; a monitor checks each handshake.
module tb_npu_out_serializer;

    localparam int NCH    = 18;
    localparam int NB     = 8;
    localparam int NBEATS = 3;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [143:0] mac_data = '0;
    logic         mac_valid = 1'b0;
    logic         relu = 1'b0;
    logic         fs = 1'b0;
    logic         rdy = 1'b0;

    logic [63:0]  out_data;
    logic [7:0]   out_keep;
    logic         out_last, out_valid, fifo_full, overflow;
    logic [15:0]  vec_count;

    beat_t        exp_q[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           m_occ = 0;
    int           m_beat = 0;
    logic         m_ov = 1'b0;
    logic [15:0]  m_cnt = '0;

    always #5 clk = ~clk;

    npu_out_serializer dut (
        .clk             (clk),
        .rstn            (rstn),
        .MAC_data_i      (mac_data),
        .MAC_data_valid_i(mac_valid),
        .relu_en_i       (relu),
        .frame_start_i   (fs),
        .out_data_o      (out_data),
        .out_keep_o      (out_keep),
        .out_last_o      (out_last),
        .out_valid_o     (out_valid),
        .out_ready_i     (rdy),
        .fifo_full_o     (fifo_full),
        .overflow_o      (overflow),
        .vec_count_o     (vec_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Expected beats straight from the channel layout: beat b holds channels b*8..b*8+7.
    task automatic push_expected(input logic [143:0] v, input logic r);
        logic [7:0] ch [NCH];
        beat_t e;
        for (int c = 0; c < NCH; c++) begin
            ch[c] = v[c*8 +: 8];
            if (r && ch[c] >= 8'h80) ch[c] = 8'h00;
        end
        for (int b = 0; b < NBEATS; b++) begin
            e = '0;
            for (int i = 0; i < NB; i++) begin
                if (b*NB + i < NCH) begin
                    e.d[i*8 +: 8] = ch[b*NB + i];
                    e.k[i] = 1'b1;
                end
            end
            e.l = (b == NBEATS - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic model_step();
        bit hs, lh, acc;
        hs  = (m_occ > 0) && rdy;
        lh  = hs && (m_beat == NBEATS - 1);
        if (hs) m_beat = lh ? 0 : m_beat + 1;
        acc = mac_valid && (m_occ < DEPTH || lh);
        if (lh) m_occ--;
        if (fs) begin
            m_ov  = 1'b0;
            m_cnt = '0;
        end
        if (lh && m_cnt != 16'hFFFF) m_cnt++;
        if (acc) begin
            m_occ++;
            push_expected(mac_data, relu);
        end else if (mac_valid) begin
            m_ov = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [143:0] v, input logic r);
        mac_data  = v;
        relu      = r;
        mac_valid = 1'b1;
        tick();
        mac_valid = 1'b0;
    endtask

    task automatic drain();
        rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!out_valid && m_occ == 0) break;
            tick();
        end
        chk("drain_done", 64'(out_valid), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_last"},  64'(out_last),  64'd0);
        chk({tag, "_keep"},  64'(out_keep),  64'd0);
        chk({tag, "_data"},  out_data,       64'd0);
        chk({tag, "_full"},  64'(fifo_full), 64'd0);
        chk({tag, "_ovf"},   64'(overflow),  64'd0);
        chk({tag, "_cnt"},   64'(vec_count), 64'd0);
    endtask

    function automatic logic [143:0] rand_vec();
        logic [143:0] v;
        for (int c = 0; c < NCH; c++) v[c*8 +: 8] = 8'($urandom);
        return v;
    endfunction

    initial begin
        logic [143:0] v;
        fork
            // Reference model: advances on every clock, async-cleared by reset.
            forever begin
                @(posedge clk or negedge rstn);
                if (!rstn) begin
                    m_occ  = 0;
                    m_beat = 0;
                    m_ov   = 1'b0;
                    m_cnt  = '0;
                end else begin
                    model_step();
                end
            end
            // Monitor: status every cycle, payload on each handshake.
            begin
                beat_t e;
                logic [72:0] held_v;
                bit held;
                held = 0;
                held_v = '0;
                forever begin
                    @(negedge clk);
                    if (!rstn) begin
                        exp_q.delete();
                        held = 0;
                    end else begin
                        chk("out_valid", 64'(out_valid), 64'(m_occ > 0));
                        chk("fifo_full", 64'(fifo_full), 64'(m_occ == DEPTH));
                        chk("overflow",  64'(overflow),  64'(m_ov));
                        chk("vec_count", 64'(vec_count), 64'(m_cnt));
                        if (out_valid && held) begin
                            chk("hold_data",      out_data, held_v[72:9]);
                            chk("hold_keep_last", 64'({out_keep, out_last}), 64'(held_v[8:0]));
                        end
                        held   = out_valid && !rdy;
                        held_v = {out_data, out_keep, out_last};
                        if (out_valid && rdy) begin
                            chk("exp_available", 64'(exp_q.size() != 0), 64'd1);
                            if (exp_q.size() != 0) begin
                                e = exp_q.pop_front();
                                chk("beat_data", out_data, e.d);
                                chk("beat_keep", 64'(out_keep), 64'(e.k));
                                chk("beat_last", 64'(out_last), 64'(e.l));
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) tick();
        chk_reset_vals("reset");
        rstn = 1'b1;
        tick();

        // Incrementing bytes 0x00..0x11, relu off, ready high.
        rdy = 1'b1;
        for (int c = 0; c < NCH; c++) v[c*8 +: 8] = 8'(c);
        send(v, 1'b0);
        repeat (5) tick();
        chk("single_vec_count", 64'(vec_count), 64'd1);

        // Alternating 0x80 / 0x7F with ReLU.
        for (int c = 0; c < NCH; c++) v[c*8 +: 8] = (c % 2 == 0) ? 8'h80 : 8'h7F;
        send(v, 1'b1);
        repeat (5) tick();

        // Backpressure for 5 cycles while beat 1 is presented.
        send(rand_vec(), 1'b0);
        tick();
        rdy = 1'b0;
        repeat (5) tick();
        drain();

        // Six back-to-back vectors with ready low: four kept, two dropped.
        fs = 1'b1;
        tick();
        fs  = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) send(rand_vec(), 1'(i % 2));
        chk("ovf_test_full", 64'(fifo_full), 64'd1);
        chk("ovf_test_ovf",  64'(overflow),  64'd1);
        drain();
        chk("ovf_test_count", 64'(vec_count), 64'd4);

        // Full FIFO, new vector lands on the head's last-beat handshake.
        fs = 1'b1;
        tick();
        fs  = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(rand_vec(), 1'b0);
        rdy = 1'b1;
        tick();
        tick();
        send(rand_vec(), 1'b0);
        chk("full_pop_ovf",  64'(overflow),  64'd0);
        chk("full_pop_full", 64'(fifo_full), 64'd1);
        drain();
        chk("full_pop_count", 64'(vec_count), 64'd5);

        // Random traffic with random backpressure and occasional frame starts.
        for (int i = 0; i < 600; i++) begin
            mac_valid = ($urandom % 3) == 0;
            mac_data  = rand_vec();
            relu      = 1'($urandom);
            rdy       = ($urandom % 10) < 7;
            fs        = ($urandom % 60) == 0;
            tick();
        end
        mac_valid = 1'b0;
        fs        = 1'b0;
        drain();

        // Reset while beat 1 of a vector is on the bus.
        fs = 1'b1;
        tick();
        fs = 1'b0;
        send(rand_vec(), 1'b0);
        tick();
        rstn = 1'b0;
        #1;
        chk_reset_vals("in_reset");
        tick();
        tick();
        rstn = 1'b1;
        tick();
        fs = 1'b1;
        tick();
        fs = 1'b0;
        repeat (6) tick();
        chk_reset_vals("post_reset");

        chk("leftover_beats", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/npu_out_serializer.md
# npu_out_serializer

Downstream stage of the pointwise-conv MAC core: it captures each 18-channel int8 result vector, optionally applies ReLU, buffers it in a small vector FIFO, and emits it as a valid/ready byte stream toward the output feature-map writer. The MAC core has no backpressure, so this block absorbs bursts. When the buffer is full it drops the vector and flags the loss.

## Interface
- MAC_OUT_NUM, 18, int8 channels per result vector
- DATA_WIDTH, 8, bits per channel
- OUT_BYTES, 8, bytes per output beat (output bus is 64 bits)
- FIFO_DEPTH, 4, vector entries buffered (power of two)
- CNT_WIDTH, 16, width of the transmitted-vector counter
- clk  in  1  single clock for the whole block
- rstn  in  1  asynchronous, active-low reset
- MAC_data_i  in  MAC_OUT_NUM*DATA_WIDTH  result vector; channel c occupies bits [c*8 +: 8]
- MAC_data_valid_i  in  1  one-cycle qualifier for MAC_data_i
- relu_en_i  in  1  sampled when a vector is written; 1 clamps negative bytes to 0
- frame_start_i  in  1  one-cycle pulse; clears overflow_o and vec_count_o
- out_data_o  out  OUT_BYTES*DATA_WIDTH  beat payload
- out_keep_o  out  OUT_BYTES  byte-valid mask
- out_last_o  out  1  final beat of a vector
- out_valid_o  out  1  beat available
- out_ready_i  in  1  consumer accepts the beat when out_valid_o is also high
- fifo_full_o  out  1  all FIFO_DEPTH entries occupied
- overflow_o  out  1  sticky; a vector was dropped
- vec_count_o  out  CNT_WIDTH  vectors fully transmitted since the last frame_start_i; saturating

## Operation
- Write: when MAC_data_valid_i is high and the write is accepted, store the vector into the FIFO. If relu_en_i is high, every byte with bit 7 set is stored as 0x00.
- Accept rule: the write is accepted if occupancy < FIFO_DEPTH, or if occupancy == FIFO_DEPTH and the head's last beat handshakes in the same cycle.
- Drop: otherwise the vector is discarded, FIFO contents are unchanged, and overflow_o is set.
- Beats: BEATS = ceil(MAC_OUT_NUM/OUT_BYTES), which is 3 at the defaults. Beat b carries channels b*8 through b*8+7, with channel b*8 in out_data_o[7:0].
  - Full beats use out_keep_o = 0xFF.
  - The final beat at the defaults carries channels 16–17 with out_keep_o = 0x03; its unused bytes are driven to 0.
- A beat counter counts 0..BEATS-1 and advances on each handshake (out_valid_o & out_ready_i). When the last beat handshakes, the counter returns to 0, the FIFO pops, and vec_count_o increments unless it is at all-ones.
- frame_start_i clears overflow_o and vec_count_o. It does not flush the FIFO or reset the beat counter.
  - If frame_start_i coincides with a drop, overflow_o ends the cycle at 1.
  - If it coincides with a last-beat handshake, vec_count_o ends the cycle at 1.

## Timing
- Reset values: out_valid_o=0, out_last_o=0, out_keep_o=0, out_data_o=0, fifo_full_o=0, overflow_o=0, vec_count_o=0. Reset also empties the FIFO and zeroes the beat counter.
- Reset asserted mid-vector discards the partial vector; no further beats of it appear after release.
- Latency: a vector written into an empty FIFO in cycle N presents beat 0 in cycle N+1.
- Throughput: one beat per cycle under continuous ready. Sustained input rate is therefore at most one vector per BEATS cycles without drops.
- While out_valid_o=1 and out_ready_i=0, out_data_o, out_keep_o and out_last_o hold stable. out_valid_o is never withdrawn without a handshake.
- The next vector's beat 0 follows the previous last beat with no bubble.
- fifo_full_o and overflow_o are registered and update in the cycle after the causing edge.

## Structure
- Shared package npu_pkg: BEATS, LAST_KEEP mask, and the output beat width constants; they are shared with the feature-map writer.
- One sub-module, npu_vec_fifo: a synchronous, registered-output FIFO of width MAC_OUT_NUM*DATA_WIDTH with occupancy count.
- The beat mux, ReLU, counters and drop logic stay in the top level.

## Test plan
- Single vector, bytes 0x00..0x11, relu off, out_ready_i tied high -> 3 beats in cycles N+1..N+3:
  - beat 0 = 0x0706050403020100, keep 0xFF
  - beat 1 = 0x0F0E0D0C0B0A0908, keep 0xFF
  - beat 2 = 0x0000000000001110, keep 0x03, last=1
  - vec_count_o ends at 1
- ReLU: vector with alternating bytes 0x80 and 0x7F, relu on -> all 0x80 bytes emitted as 0x00, all 0x7F bytes unchanged.
- Backpressure: hold out_ready_i low for 5 cycles during beat 1 -> beat 1 is held stable, no beat is skipped or duplicated, and the order is preserved.
- Overflow: 6 back-to-back vectors with out_ready_i low -> 4 accepted, fifo_full_o=1, overflow_o=1. Releasing ready emits exactly 4 vectors; vec_count_o ends at 4.
- Full and pop in the same cycle: FIFO full, a new vector arrives in the cycle the head's last beat handshakes -> it is accepted, overflow_o stays 0, and occupancy stays 4.
- Reset during beat 1 of a vector, then frame_start_i after release -> all outputs return to their reset values, no stale beats appear, and vec_count_o is 0.
